// File: rtl/trace_pkg.sv
// Shared types for the trace capture unit: FSM state encoding and mode values.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam logic TRACE_MODE_FIFO_STOP   = 1'b0;
  localparam logic TRACE_MODE_TRIG_WINDOW = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port
// (1-cycle latency). Read data holds between enabled reads; array is not reset.
module trace_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage write.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read; only the output register is reset.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Trigger-qualified trace capture buffer: selects one channel, logs it into a
// circular RAM (stop-when-full or pre/post-trigger window), then freezes and
// drains oldest-first through a valid-qualified read port.
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int Fpay     = 32,
  parameter int TB_DEPTH = 512,
  parameter int CH_NUM   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CH_NUM*Fpay-1:0]               ch_din,
  input  logic [CH_NUM-1:0]                    ch_wr,
  input  logic [$clog2(CH_NUM>1?CH_NUM:2)-1:0] ch_sel,
  input  logic                                 mode,
  input  logic [$clog2(TB_DEPTH)-1:0]          post_cnt,
  input  logic                                 arm,
  input  logic                                 trig,
  input  logic                                 rd_req,
  output logic                                 rd_valid,
  output logic [Fpay-1:0]                      rd_data,
  output logic [1:0]                           state,
  output logic [$clog2(TB_DEPTH):0]            count,
  output logic                                 wrapped,
  output logic [$clog2(TB_DEPTH)-1:0]          trig_addr
);

  localparam int AW = $clog2(TB_DEPTH);
  localparam int CW = $clog2(CH_NUM > 1 ? CH_NUM : 2);
  localparam logic [AW:0] FULL = (AW+1)'(TB_DEPTH);

  trace_state_t  state_q, state_d;
  logic [CW-1:0] ch_sel_q;
  logic          mode_q;
  logic [AW-1:0] post_q, post_left, post_left_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, trig_addr_d;
  logic [AW:0]   count_d;
  logic          wrapped_d;
  logic          we, rd_acc;
  logic [Fpay-1:0] wr_word;

  assign wr_word = ch_din[ch_sel_q*Fpay +: Fpay];
  assign state   = state_q;

  // Next-state and datapath decode; arm overrides everything else.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    count_d     = count;
    wrapped_d   = wrapped;
    trig_addr_d = trig_addr;
    post_left_d = post_left;
    we          = 1'b0;
    rd_acc      = 1'b0;
    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wrapped_d   = 1'b0;
      trig_addr_d = '0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          we = ch_wr[ch_sel_q];
          if (we) begin
            wr_ptr_d = wr_ptr + 1'b1;
            if (count != FULL) count_d = count + 1'b1;
            else if (mode_q == TRACE_MODE_TRIG_WINDOW) wrapped_d = 1'b1;
          end
          if (mode_q == TRACE_MODE_FIFO_STOP) begin
            if (we && count == FULL - 1'b1) state_d = ST_DONE;
          end else if (state_q == ST_ARMED) begin
            // A write coinciding with trig is the trigger sample itself and
            // does not consume a post-trigger slot.
            if (trig) begin
              trig_addr_d = wr_ptr;
              post_left_d = post_q;
              state_d     = (post_q == '0) ? ST_DONE : ST_POST;
            end
          end else if (we) begin
            post_left_d = post_left - 1'b1;
            if (post_left == AW'(1)) state_d = ST_DONE;
          end
          // Oldest entry: the slot about to be overwritten once the ring is full.
          if (state_d == ST_DONE) rd_ptr_d = (count_d == FULL) ? wr_ptr_d : '0;
        end
        ST_DONE: begin
          rd_acc = rd_req && (count != '0);
          if (rd_acc) begin
            rd_ptr_d = rd_ptr + 1'b1;
            count_d  = count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Pointers, counters, status and the capture configuration sampled on arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
      post_left <= '0;
      rd_valid  <= 1'b0;
      ch_sel_q  <= '0;
      mode_q    <= TRACE_MODE_FIFO_STOP;
      post_q    <= '0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      count     <= count_d;
      wrapped   <= wrapped_d;
      trig_addr <= trig_addr_d;
      post_left <= post_left_d;
      rd_valid  <= rd_acc;
      if (arm) begin
        ch_sel_q <= ch_sel;
        mode_q   <= mode;
        post_q   <= post_cnt;
      end
    end
  end

  trace_ram #(.DATA_WIDTH(Fpay), .ADDR_WIDTH(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit (depth 8, 4 channels) with a
// queue-based reference model compared against the DUT every cycle.
module tb_trace_capture_unit;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] ch_din = '0;
  logic [3:0]   ch_wr = '0;
  logic [1:0]   ch_sel = '0;
  logic         mode = 1'b0;
  logic [2:0]   post_cnt = '0;
  logic         arm = 1'b0, trig = 1'b0, rd_req = 1'b0;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic [1:0]   state;
  logic [3:0]   count;
  logic         wrapped;
  logic [2:0]   trig_addr;

  trace_capture_unit #(.Fpay(32), .TB_DEPTH(DEPTH), .CH_NUM(4)) dut (
    .clk(clk), .reset(reset), .ch_din(ch_din), .ch_wr(ch_wr), .ch_sel(ch_sel),
    .mode(mode), .post_cnt(post_cnt), .arm(arm), .trig(trig), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .state(state), .count(count),
    .wrapped(wrapped), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: history of captured words, readout list built at freeze.
  int          m_st = 0, m_cnt = 0, m_ta = 0, m_pl = 0, m_sel = 0, m_pc = 0;
  bit          m_wrp = 0, m_rv = 0, m_md = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] hist[$];
  logic [31:0] rq[$];
  logic [31:0] got[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit w, done;
    done = 0;
    if (reset) begin
      m_st = 0; m_ta = 0; m_wrp = 0; m_rv = 0; m_rd = '0;
      hist.delete(); rq.delete();
    end else begin
      m_rv = 0;
      if (arm) begin
        m_st = 1; m_ta = 0; m_wrp = 0;
        hist.delete(); rq.delete();
        m_sel = int'(ch_sel); m_md = mode; m_pc = int'(post_cnt);
      end else if (m_st == 1 || m_st == 2) begin
        w = ch_wr[m_sel];
        if (w) hist.push_back(ch_din[m_sel*32 +: 32]);
        if (!m_md) begin
          if (hist.size() == DEPTH) done = 1;
        end else if (m_st == 1) begin
          if (trig) begin
            m_ta = (hist.size() - (w ? 1 : 0)) % DEPTH;
            m_pl = m_pc;
            if (m_pc == 0) done = 1; else m_st = 2;
          end
        end else if (w) begin
          m_pl--;
          if (m_pl == 0) done = 1;
        end
        m_wrp = m_md && (hist.size() > DEPTH);
        if (done) begin
          m_st = 3;
          for (int i = (hist.size() > DEPTH ? hist.size() - DEPTH : 0); i < hist.size(); i++)
            rq.push_back(hist[i]);
        end
      end else if (m_st == 3) begin
        if (rd_req && rq.size() > 0) begin
          m_rd = rq.pop_front();
          m_rv = 1;
        end
      end
    end
    m_cnt = (m_st == 3) ? rq.size() : (hist.size() > DEPTH ? DEPTH : hist.size());
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("state", state, m_st);
      chk("count", count, m_cnt);
      chk("wrapped", wrapped, m_wrp);
      chk("trig_addr", trig_addr, m_ta);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_data", rd_data, m_rd);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm(bit m, int s, int pc);
    mode = m; ch_sel = 2'(s); post_cnt = 3'(pc); arm = 1; tick(); arm = 0;
  endtask

  // Write v on channel s, with noise on another channel that must be ignored.
  task automatic push(int s, int v, bit t);
    int n;
    n = (s + 2) % 4;
    ch_din = '0;
    ch_din[s*32 +: 32] = 32'(v);
    ch_din[n*32 +: 32] = 32'hdead_0000 | 32'(v);
    ch_wr = (4'b1 << s) | (4'b1 << n);
    trig = t;
    tick();
    ch_wr = '0; trig = 0;
  endtask

  task automatic drain(int n);
    got.delete();
    rd_req = 1;
    repeat (n) begin
      tick();
      if (rd_valid) got.push_back(rd_data);
    end
    rd_req = 0;
  endtask

  initial begin
    fork monitor(); join_none
    tick(); tick();
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);
    reset = 0;

    // FIFO_STOP on ch 2: stops after 8 words, drains 0..7.
    do_arm(0, 2, 0);
    for (int i = 0; i < 10; i++) push(2, i, 0);
    chk("fifo_done", state, 3);
    chk("fifo_full", count, 8);
    drain(10);
    chk("fifo_ndrain", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("fifo_word", got[k], k);
    chk("fifo_empty", count, 0);
    chk("fifo_wrapped", wrapped, 0);

    // TRIG_WINDOW, post 3, trigger on word 6: window is words 2..9.
    do_arm(1, 1, 3);
    for (int i = 0; i < 12; i++) push(1, i, i == 6);
    chk("win_done", state, 3);
    chk("win_taddr", trig_addr, 6);
    chk("win_wrapped", wrapped, 1);
    drain(10);
    chk("win_ndrain", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("win_word", got[k], k + 2);

    // TRIG_WINDOW, post 0, trigger with word 3: freeze immediately.
    do_arm(1, 3, 0);
    for (int i = 0; i < 4; i++) push(3, i, i == 3);
    chk("p0_done", state, 3);
    chk("p0_count", count, 4);
    chk("p0_taddr", trig_addr, 3);
    drain(6);
    chk("p0_ndrain", got.size(), 4);
    for (int k = 0; k < got.size(); k++) chk("p0_word", got[k], k);

    // Re-arm mid-POST after a wrap.
    do_arm(1, 0, 5);
    for (int i = 0; i < 11; i++) push(0, i, i == 9);
    chk("post_state", state, 2);
    do_arm(0, 0, 0);
    chk("rearm_state", state, 1);
    chk("rearm_count", count, 0);
    chk("rearm_wrapped", wrapped, 0);
    for (int i = 0; i < 8; i++) push(0, 'h100 + i, 0);
    drain(3);
    for (int k = 0; k < got.size(); k++) chk("part_word", got[k], 'h100 + k);
    // Re-arm mid-drain.
    do_arm(0, 0, 0);
    chk("rearm2_state", state, 1);
    chk("rearm2_count", count, 0);
    for (int i = 0; i < 8; i++) push(0, 'h200 + i, 0);
    drain(8);
    chk("new_ndrain", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("new_word", got[k], 'h200 + k);

    // Reset while in POST; trig afterwards must do nothing.
    do_arm(1, 1, 4);
    push(1, 'h300, 0); push(1, 'h301, 1); push(1, 'h302, 0);
    chk("pre_rst_state", state, 2);
    reset = 1; tick();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_taddr", trig_addr, 0);
    reset = 0;
    push(1, 'h303, 1); push(1, 'h304, 1);
    chk("idle_state", state, 0);
    chk("idle_count", count, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
